// File: rtl/ptp_tx_gen_if.sv
// Request/response and GMII transmit bundle for the PTP event-frame generator.
// The master side requests frames and supplies RTC time; the slave side is the generator.
interface ptp_tx_gen_if;
    logic [79:0] rtc_timer_in;
    logic        tx_req;
    logic [3:0]  tx_msgid;
    logic [15:0] tx_seqid;
    logic        tx_busy;
    logic        tx_done;
    logic [79:0] tx_ts;
    logic        gmii_ctrl;
    logic [7:0]  gmii_data;

    modport master (
        output rtc_timer_in, tx_req, tx_msgid, tx_seqid,
        input  tx_busy, tx_done, tx_ts, gmii_ctrl, gmii_data
    );

    modport slave (
        input  rtc_timer_in, tx_req, tx_msgid, tx_seqid,
        output tx_busy, tx_done, tx_ts, gmii_ctrl, gmii_data
    );
endinterface

// File: rtl/ptp_tx_gen.sv
// One-step PTP event-frame transmitter: preamble, 60-byte L2 PTP frame with the
// RTC time captured at the SFD edge, CRC-32 FCS and inter-frame gap on GMII.
module ptp_tx_gen #(
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [63:0] CLOCK_ID = 64'h000A35FFFE000001,
    parameter logic [15:0] PORT_NUM = 16'h0001
) (
    input  logic         gmii_clk,
    input  logic         rst,
    ptp_tx_gen_if.slave  tx_if
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_FRAME = 3'd2,
        S_FCS   = 3'd3,
        S_IFG   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_cnt;
    logic        w_accept;
    logic [3:0]  r_msgid;
    logic [15:0] r_seqid;
    logic [79:0] r_ts;
    logic [31:0] r_crc;
    logic [7:0]  r_data;
    logic        r_ctrl;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  w_frame_byte;
    logic [7:0]  w_fcs_byte;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[31:1]} ^ 32'hEDB88320;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] control_field(input logic [3:0] msgid);
        logic [7:0] cf;
        case (msgid)
            4'h0:    cf = 8'h00;
            4'h1:    cf = 8'h01;
            default: cf = 8'h05;
        endcase
        return cf;
    endfunction

    // Next-state decode; the last IFG cycle also samples tx_req so a held
    // request restarts exactly 12 idle cycles after the previous FCS.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_if.tx_req) begin
                    w_state_nxt = S_PRE;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRE: begin
                if (r_cnt == 7'd7) w_state_nxt = S_FRAME;
                else               w_state_nxt = S_PRE;
            end
            S_FRAME: begin
                if (r_cnt == 7'd59) w_state_nxt = S_FCS;
                else                w_state_nxt = S_FRAME;
            end
            S_FCS: begin
                if (r_cnt == 7'd3) w_state_nxt = S_IFG;
                else               w_state_nxt = S_FCS;
            end
            S_IFG: begin
                if (r_cnt == 7'd11) begin
                    if (tx_if.tx_req) begin
                        w_state_nxt = S_PRE;
                        w_accept    = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IFG;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and byte counter, cleared on every state change.
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 7'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_cnt <= 7'd0;
            else                                                 r_cnt <= r_cnt + 7'd1;
        end
    end

    // Request fields captured on accept so the frame in flight is stable.
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            r_msgid <= 4'h0;
            r_seqid <= 16'h0000;
        end else if (w_accept) begin
            r_msgid <= tx_if.tx_msgid;
            r_seqid <= tx_if.tx_seqid;
        end
    end

    // FRAME byte map indexed by the byte counter.
    always_comb begin
        w_frame_byte = 8'h00;
        case (r_cnt)
            7'd0:    w_frame_byte = 8'h01;
            7'd1:    w_frame_byte = 8'h1B;
            7'd2:    w_frame_byte = 8'h19;
            7'd6:    w_frame_byte = SRC_MAC[47:40];
            7'd7:    w_frame_byte = SRC_MAC[39:32];
            7'd8:    w_frame_byte = SRC_MAC[31:24];
            7'd9:    w_frame_byte = SRC_MAC[23:16];
            7'd10:   w_frame_byte = SRC_MAC[15:8];
            7'd11:   w_frame_byte = SRC_MAC[7:0];
            7'd12:   w_frame_byte = 8'h88;
            7'd13:   w_frame_byte = 8'hF7;
            7'd14:   w_frame_byte = {4'h0, r_msgid};
            7'd15:   w_frame_byte = 8'h02;
            7'd17:   w_frame_byte = 8'h2C;
            7'd34:   w_frame_byte = CLOCK_ID[63:56];
            7'd35:   w_frame_byte = CLOCK_ID[55:48];
            7'd36:   w_frame_byte = CLOCK_ID[47:40];
            7'd37:   w_frame_byte = CLOCK_ID[39:32];
            7'd38:   w_frame_byte = CLOCK_ID[31:24];
            7'd39:   w_frame_byte = CLOCK_ID[23:16];
            7'd40:   w_frame_byte = CLOCK_ID[15:8];
            7'd41:   w_frame_byte = CLOCK_ID[7:0];
            7'd42:   w_frame_byte = PORT_NUM[15:8];
            7'd43:   w_frame_byte = PORT_NUM[7:0];
            7'd44:   w_frame_byte = r_seqid[15:8];
            7'd45:   w_frame_byte = r_seqid[7:0];
            7'd46:   w_frame_byte = control_field(r_msgid);
            7'd47:   w_frame_byte = 8'h7F;
            7'd48:   w_frame_byte = r_ts[79:72];
            7'd49:   w_frame_byte = r_ts[71:64];
            7'd50:   w_frame_byte = r_ts[63:56];
            7'd51:   w_frame_byte = r_ts[55:48];
            7'd52:   w_frame_byte = r_ts[47:40];
            7'd53:   w_frame_byte = r_ts[39:32];
            7'd54:   w_frame_byte = r_ts[31:24];
            7'd55:   w_frame_byte = r_ts[23:16];
            7'd56:   w_frame_byte = r_ts[15:8];
            7'd57:   w_frame_byte = r_ts[7:0];
            default: w_frame_byte = 8'h00;
        endcase
    end

    // FCS is the complemented CRC, least-significant byte first.
    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_fcs_byte = ~r_crc[7:0];
            2'd1:    w_fcs_byte = ~r_crc[15:8];
            2'd2:    w_fcs_byte = ~r_crc[23:16];
            2'd3:    w_fcs_byte = ~r_crc[31:24];
            default: w_fcs_byte = 8'h00;
        endcase
    end

    // Registered GMII outputs, CRC accumulation and SFD-edge timestamp capture.
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            r_ctrl <= 1'b0;
            r_data <= 8'h00;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ts   <= 80'h0;
            r_crc  <= 32'hFFFFFFFF;
        end else begin
            r_ctrl <= 1'b0;
            r_data <= 8'h00;
            r_done <= 1'b0;
            r_busy <= (r_state != S_IDLE);
            case (r_state)
                S_PRE: begin
                    r_ctrl <= 1'b1;
                    r_crc  <= 32'hFFFFFFFF;
                    if (r_cnt == 7'd7) begin
                        r_data <= 8'hD5;
                        r_ts   <= tx_if.rtc_timer_in;
                    end else begin
                        r_data <= 8'h55;
                    end
                end
                S_FRAME: begin
                    r_ctrl <= 1'b1;
                    r_data <= w_frame_byte;
                    r_crc  <= crc32_byte(r_crc, w_frame_byte);
                end
                S_FCS: begin
                    r_ctrl <= 1'b1;
                    r_data <= w_fcs_byte;
                end
                S_IFG: begin
                    r_done <= (r_cnt == 7'd0);
                end
                default: begin
                    r_ctrl <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.gmii_ctrl = r_ctrl;
    assign tx_if.gmii_data = r_data;
    assign tx_if.tx_busy   = r_busy;
    assign tx_if.tx_done   = r_done;
    assign tx_if.tx_ts     = r_ts;

endmodule

// File: tb/tb_ptp_tx_gen.sv
// Self-checking bench for ptp_tx_gen: table of frame requests plus hand-written
// timing corner sequences; a scoreboard queue holds the expected frame bytes.
module tb_ptp_tx_gen;

    logic        gmii_clk = 1'b0;
    logic        rst;
    logic [31:0] rtc_step;

    ptp_tx_gen_if tx_if();

    ptp_tx_gen dut (
        .gmii_clk (gmii_clk),
        .rst      (rst),
        .tx_if    (tx_if)
    );

    always #5 gmii_clk = ~gmii_clk;

    typedef struct packed {
        logic [543:0] bytes;
        logic [79:0]  ts;
    } frame_t;

    typedef struct {
        logic [3:0]  m;
        logic [15:0] s;
        logic [79:0] rtc;
        logic [7:0]  cf;
    } vec_t;

    frame_t q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     pcyc = 0;
    int     done_cnt = 0;
    int     done_cyc_last = 0;
    int     done_cyc_prev = 0;
    int     frames_seen = 0;
    int     end_cyc = 0;
    int     last_gap = 0;
    logic   expect_trunc = 1'b0;

    // monitor-private state
    logic        in_frame = 1'b0;
    logic        have_exp = 1'b0;
    int          pos = 0;
    logic [31:0] mcrc;
    frame_t      cur;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [543:0] build_frame(input logic [3:0] m, input logic [15:0] s,
                                                 input logic [79:0] ts, input logic [7:0] cf);
        logic [7:0]   f [0:67];
        logic [543:0] r;
        for (int i = 0; i < 68; i++) f[i] = 8'h00;
        for (int i = 0; i < 7; i++)  f[i] = 8'h55;
        f[7]  = 8'hD5;
        f[8]  = 8'h01; f[9]  = 8'h1B; f[10] = 8'h19;
        f[14] = 8'h00; f[15] = 8'h0A; f[16] = 8'h35; f[17] = 8'h00; f[18] = 8'h00; f[19] = 8'h01;
        f[20] = 8'h88; f[21] = 8'hF7;
        f[22] = {4'h0, m};
        f[23] = 8'h02;
        f[25] = 8'h2C;
        f[42] = 8'h00; f[43] = 8'h0A; f[44] = 8'h35; f[45] = 8'hFF;
        f[46] = 8'hFE; f[47] = 8'h00; f[48] = 8'h00; f[49] = 8'h01;
        f[50] = 8'h00; f[51] = 8'h01;
        f[52] = s[15:8]; f[53] = s[7:0];
        f[54] = cf;
        f[55] = 8'h7F;
        for (int i = 0; i < 10; i++) f[56+i] = ts[79-8*i -: 8];
        for (int i = 0; i < 68; i++) r[i*8 +: 8] = f[i];
        return r;
    endfunction

    task automatic push_frame(input logic [3:0] m, input logic [15:0] s,
                              input logic [79:0] ts, input logic [7:0] cf);
        frame_t fr;
        fr.bytes = build_frame(m, s, ts, cf);
        fr.ts    = ts;
        q.push_back(fr);
    endtask

    // Called just after a falling edge; returns at the cycle-0 sample point.
    task automatic start_req(input logic [3:0] m, input logic [15:0] s);
        tx_if.tx_msgid = m;
        tx_if.tx_seqid = s;
        tx_if.tx_req   = 1'b1;
        @(negedge gmii_clk);
        tx_if.tx_req   = 1'b0;
    endtask

    always @(posedge gmii_clk) pcyc <= pcyc + 1;

    initial begin
        tx_if.rtc_timer_in = 80'h0;
        rtc_step = 32'd0;
        forever begin
            @(posedge gmii_clk);
            #1;
            tx_if.rtc_timer_in = tx_if.rtc_timer_in + {48'h0, rtc_step};
        end
    end

    // Output monitor: pops expected frames, checks bytes, timestamp, length, FCS and done.
    always @(negedge gmii_clk) begin
        logic ended_ok;
        ended_ok = 1'b0;
        if (tx_if.gmii_ctrl) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                pos      = 0;
                mcrc     = 32'hFFFFFFFF;
                frames_seen++;
                last_gap = pcyc - end_cyc;
                have_exp = (q.size() > 0);
                check("frame_expected", {79'h0, have_exp}, 80'h1);
                if (have_exp) cur = q.pop_front();
            end
            if (have_exp && pos < 68)
                check($sformatf("byte%0d", pos), {72'h0, tx_if.gmii_data}, {72'h0, cur.bytes[pos*8 +: 8]});
            if (have_exp && pos == 7)
                check("ts_at_sfd", tx_if.tx_ts, cur.ts);
            if (pos >= 8) mcrc = crc_upd(mcrc, tx_if.gmii_data);
            pos++;
        end else if (in_frame) begin
            in_frame = 1'b0;
            end_cyc  = pcyc;
            if (!expect_trunc) begin
                ended_ok = 1'b1;
                check("frame_len", pos, 72);
                check("fcs_residue", {48'h0, bitrev32(mcrc)}, {48'h0, 32'hC704DD7B});
                check("done_at_end", {79'h0, tx_if.tx_done}, 80'h1);
            end
        end
        if (tx_if.tx_done) begin
            done_cnt++;
            done_cyc_prev = done_cyc_last;
            done_cyc_last = pcyc;
            if (!ended_ok) check("stray_done", {79'h0, tx_if.tx_done}, 80'h0);
        end
    end

    initial begin
        vec_t vt [5];
        int   acc;
        int   d0;
        int   f0;

        vt[0] = '{4'h0, 16'h1234, 80'h00000000_0001_3B9AC9FF, 8'h00};
        vt[1] = '{4'h1, 16'hABCD, 80'h00000000_1234_00000005, 8'h01};
        vt[2] = '{4'hB, 16'h00FF, 80'h00000ABC_DEF0_3B9AC9FE, 8'h05};
        vt[3] = '{4'h3, 16'hFFFF, 80'hFFFFFFFF_FFFF_FFFFFFFF, 8'h05};
        vt[4] = '{4'h2, 16'h0000, 80'h80000000_0001_00000000, 8'h05};

        rst = 1'b1;
        tx_if.tx_req   = 1'b0;
        tx_if.tx_msgid = 4'h0;
        tx_if.tx_seqid = 16'h0;
        repeat (3) @(negedge gmii_clk);
        check("rst_ctrl", {79'h0, tx_if.gmii_ctrl}, 80'h0);
        check("rst_data", {72'h0, tx_if.gmii_data}, 80'h0);
        check("rst_busy", {79'h0, tx_if.tx_busy}, 80'h0);
        check("rst_done", {79'h0, tx_if.tx_done}, 80'h0);
        check("rst_ts", tx_if.tx_ts, 80'h0);
        rst = 1'b0;
        repeat (2) @(negedge gmii_clk);

        // table-driven single frames with constant RTC
        for (int k = 0; k < 5; k++) begin
            @(negedge gmii_clk);
            tx_if.rtc_timer_in = vt[k].rtc;
            rtc_step = 32'd0;
            push_frame(vt[k].m, vt[k].s, vt[k].rtc, vt[k].cf);
            d0 = done_cnt;
            start_req(vt[k].m, vt[k].s);
            acc = pcyc;
            check("busy_c0", {79'h0, tx_if.tx_busy}, 80'h0);
            @(negedge gmii_clk);
            check("busy_c1", {79'h0, tx_if.tx_busy}, 80'h1);
            check("ctrl_c1", {79'h0, tx_if.gmii_ctrl}, 80'h1);
            repeat (83) @(negedge gmii_clk);
            check("busy_c84", {79'h0, tx_if.tx_busy}, 80'h1);
            @(negedge gmii_clk);
            check("busy_c85", {79'h0, tx_if.tx_busy}, 80'h0);
            check("done_count", done_cnt, d0 + 1);
            check("done_cycle", done_cyc_last - acc, 73);
            check("ts_hold", tx_if.tx_ts, vt[k].rtc);
        end

        // capture edge: RTC ramps by 8 per cycle from 0 at the accept edge
        @(negedge gmii_clk);
        tx_if.rtc_timer_in = 80'h0;
        rtc_step = 32'd8;
        push_frame(4'h0, 16'h0042, 80'h40, 8'h00);
        start_req(4'h0, 16'h0042);
        repeat (90) @(negedge gmii_clk);
        rtc_step = 32'd0;
        check("capture_ts", tx_if.tx_ts, 80'h40);

        // back-to-back: request held through two accepts
        @(negedge gmii_clk);
        tx_if.rtc_timer_in = 80'h00000000_0002_00000010;
        push_frame(4'h0, 16'h0001, 80'h00000000_0002_00000010, 8'h00);
        push_frame(4'h0, 16'h0002, 80'h00000000_0002_00000010, 8'h00);
        d0 = done_cnt;
        tx_if.tx_msgid = 4'h0;
        tx_if.tx_seqid = 16'h0001;
        tx_if.tx_req   = 1'b1;
        repeat (11) @(negedge gmii_clk);
        tx_if.tx_seqid = 16'h0002;
        repeat (90) @(negedge gmii_clk);
        tx_if.tx_req   = 1'b0;
        repeat (100) @(negedge gmii_clk);
        check("b2b_done_count", done_cnt, d0 + 2);
        check("b2b_done_spacing", done_cyc_last - done_cyc_prev, 84);
        check("b2b_gap", last_gap, 12);

        // request during busy is dropped; seqid latched at accept
        @(negedge gmii_clk);
        push_frame(4'h0, 16'h5555, 80'h00000000_0002_00000010, 8'h00);
        f0 = frames_seen;
        start_req(4'h0, 16'h5555);
        repeat (5) @(negedge gmii_clk);
        tx_if.tx_seqid = 16'hAAAA;
        repeat (25) @(negedge gmii_clk);
        tx_if.tx_req = 1'b1;
        @(negedge gmii_clk);
        tx_if.tx_req = 1'b0;
        repeat (150) @(negedge gmii_clk);
        check("drop_frames", frames_seen, f0 + 1);
        check("drop_queue", q.size(), 0);

        // mid-frame reset at cycle 40
        @(negedge gmii_clk);
        expect_trunc = 1'b1;
        push_frame(4'h1, 16'h0777, 80'h00000000_0002_00000010, 8'h01);
        d0 = done_cnt;
        start_req(4'h1, 16'h0777);
        repeat (39) @(negedge gmii_clk);
        rst = 1'b1;
        @(negedge gmii_clk);
        check("rst40_ctrl", {79'h0, tx_if.gmii_ctrl}, 80'h0);
        check("rst40_busy", {79'h0, tx_if.tx_busy}, 80'h0);
        check("rst40_data", {72'h0, tx_if.gmii_data}, 80'h0);
        check("rst40_ts", tx_if.tx_ts, 80'h0);
        rst = 1'b0;
        repeat (100) @(negedge gmii_clk);
        check("rst40_no_done", done_cnt, d0);
        expect_trunc = 1'b0;
        push_frame(4'h1, 16'h0778, 80'h00000000_0002_00000010, 8'h01);
        start_req(4'h1, 16'h0778);
        repeat (90) @(negedge gmii_clk);
        check("post_rst_done", done_cnt, d0 + 1);
        check("final_queue", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ptp_tx_gen.md
# ptp_tx_gen

Transmit-side PTP event-frame generator: on request it emits a complete layer-2 (EtherType 0x88F7) PTP event frame on a GMII transmit interface, one-step style. The originTimestamp field carries the RTC time captured when the SFD byte is driven. It is the transmit-direction counterpart of the receive time-stamping unit and shares its GMII byte interface and 80-bit RTC time format: {seconds[47:0], nanoseconds[31:0]}.

## Interface
- SRC_MAC, 48'h00_0A_35_00_00_01, Ethernet source address
- CLOCK_ID, 64'h000A35FFFE000001, sourcePortIdentity.clockIdentity
- PORT_NUM, 16'h0001, sourcePortIdentity.portNumber
- gmii_clk  in  1  byte clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rtc_timer_in  in  80  RTC time {s[47:0], ns[31:0]}, synchronous to gmii_clk
- tx_req  in  1  frame request, sampled only in IDLE
- tx_msgid  in  4  messageType, latched on accept
- tx_seqid  in  16  sequenceId, latched on accept
- tx_busy  out  1  high from the cycle after accept through the last IFG cycle
- tx_done  out  1  one-cycle pulse after the last FCS byte
- tx_ts  out  80  timestamp inserted in the last frame; holds its value until the next SFD
- gmii_ctrl  out  1  TX_EN
- gmii_data  out  8  TXD

## Operation
- States:
  - IDLE: outputs low; tx_req=1 -> PRE.
  - PRE: 8 bytes: 7×0x55, then 0xD5 (SFD); then -> FRAME.
  - FRAME: 60 bytes; then -> FCS.
  - FCS: 4 bytes; then -> IFG.
  - IFG: 12 cycles with gmii_ctrl=0; then -> IDLE.
- Use one 7-bit byte counter, cleared on every state change.
- FRAME byte map (index 0..59):
  - 0-5: destination MAC 01:1B:19:00:00:00
  - 6-11: SRC_MAC, MSB first
  - 12-13: 88 F7
  - 14: {4'h0, msgid}
  - 15: 0x02
  - 16-17: messageLength 00 2C
  - 18-19: 00 (domainNumber, reserved)
  - 20-21: flags 00 00
  - 22-29: correctionField 0
  - 30-33: reserved 0
  - 34-41: CLOCK_ID, MSB first
  - 42-43: PORT_NUM
  - 44-45: seqid, MSB first
  - 46: controlField: 0x00 if msgid=0, 0x01 if msgid=1, else 0x05
  - 47: logMessageInterval 0x7F
  - 48-53: ts seconds, MSB first
  - 54-57: ts nanoseconds, MSB first
  - 58-59: pad 00
- CRC-32 (IEEE 802.3, reflected polynomial 0xEDB88320, init 0xFFFFFFFF) covers FRAME bytes 0-59, updated byte-serially as each byte is driven.
- FCS = ~crc, transmitted least-significant byte first.
- Timestamp: the value of rtc_timer_in at the clock edge that registers 0xD5 onto gmii_data is latched into tx_ts and is the value serialized in bytes 48-57. No correction is applied.
- tx_req while busy is ignored, not queued. Holding tx_req high gives back-to-back frames separated by exactly 12 idle cycles.
- msgid and seqid are latched at accept; later input changes do not affect the frame in flight.
- rst at any point:
  - next edge: state IDLE; gmii_ctrl, gmii_data, tx_busy, tx_done, tx_ts all 0.
  - A truncated frame is not completed and produces no tx_done.

## Timing
- Reset values: every output 0.
- All outputs are registered.
- Accept edge = cycle 0 (IDLE, tx_req=1).
- Cycles 1-7: 0x55. Cycle 8: 0xD5.
- Cycles 9-68: FRAME bytes. Cycles 69-72: FCS.
- gmii_ctrl is high in cycles 1-72 only (72 bytes).
- tx_busy is high in cycles 1-84.
- tx_done=1 in cycle 73 only.
- The earliest next accept edge is cycle 84; its first preamble byte appears in cycle 85.
- tx_ts updates in cycle 8, the same cycle as the SFD.

## Test plan
- **Single Sync.** msgid=0, seqid=0x1234, rtc held at 0x00000000_0001_3B9AC9FF.
  - 72 ctrl-high cycles.
  - Bytes 44-47 = 12 34 00 7F.
  - Bytes 48-57 = 00 00 00 00 00 01 3B 9A C9 FF.
  - CRC-32 over FRAME+FCS gives residue 0xC704DD7B.
  - tx_done in cycle 73.
- **Capture edge.** rtc increments by 8 every cycle from 0 at the accept edge.
  - tx_ts and bytes 48-57 equal the rtc value sampled at the SFD edge, i.e. 0x40.
- **Back-to-back.** tx_req held high for two frames.
  - gmii_ctrl low for exactly 12 cycles between frames.
  - Two tx_done pulses, 84 cycles apart.
- **Busy drop and input latching.** tx_req pulsed in cycle 30; tx_seqid changed in cycle 5.
  - Only one frame is sent.
  - It carries the seqid latched at accept.
- **Mid-frame reset.** rst asserted in cycle 40.
  - gmii_ctrl=0 and tx_busy=0 at the next edge; no tx_done.
  - A fresh request then produces a full, CRC-valid frame.
- **controlField mapping.** msgid=1 -> byte 46 = 0x01; msgid=0xB -> byte 46 = 0x05, byte 14 = 0x0B.
